// File: rtl/hazard_detect.sv
// Hazard detection for the non-forwarding pipeline: tracks in-flight destination
// registers for EX/MEM/WB and produces the hazard_op code for the pipeline register control.
module hazard_detect #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rd_wren_i,
  input  logic             mem_br_taken_i,
  output logic [1:0]       hazard_op_o,
  output logic [CNT_W-1:0] data_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_DATA = 2'd1,
    OP_CTRL = 2'd2
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       rs1_hit, rs2_hit;
  op_e        op;

  function automatic logic src_hit(
    input logic [4:0] rs,
    input logic       ex_v,
    input logic [4:0] ex_r,
    input logic       mem_v,
    input logic [4:0] mem_r,
    input logic       wb_v,
    input logic [4:0] wb_r
  );
    logic hit;
    hit = (ex_v && (ex_r == rs)) || (mem_v && (mem_r == rs));
    if (!WB_BYPASS) hit = hit || (wb_v && (wb_r == rs));
    return (rs != 5'd0) && hit;
  endfunction

  always_comb begin
    rs1_hit = id_valid_i && id_rs1_used_i &&
              src_hit(id_rs1_addr_i, ex_valid, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);
    rs2_hit = id_valid_i && id_rs2_used_i &&
              src_hit(id_rs2_addr_i, ex_valid, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);
  end

  // Control beats data; reset forces the op quiet even with a branch pending on the inputs.
  always_comb begin
    op = OP_NONE;
    if (!rst_ni)             op = OP_NONE;
    else if (mem_br_taken_i) op = OP_CTRL;
    else if (rs1_hit || rs2_hit) op = OP_DATA;
  end

  assign hazard_op_o = op;

  // The rd fields shift unconditionally; only the valid bits decide whether a slot matters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      ex_rd     <= 5'd0;
      mem_rd    <= 5'd0;
      wb_rd     <= 5'd0;
    end else begin
      wb_valid <= mem_valid;
      wb_rd    <= mem_rd;
      mem_rd   <= ex_rd;
      ex_rd    <= id_rd_addr_i;
      case (op)
        OP_NONE: begin
          mem_valid <= ex_valid;
          ex_valid  <= id_valid_i && id_rd_wren_i && (id_rd_addr_i != 5'd0);
        end
        OP_DATA: begin
          mem_valid <= ex_valid;
          ex_valid  <= 1'b0;
        end
        default: begin
          mem_valid <= 1'b0;
          ex_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_stall_cnt_o <= '0;
      flush_cnt_o      <= '0;
    end else begin
      if (op == OP_DATA && data_stall_cnt_o != CNT_MAX)
        data_stall_cnt_o <= data_stall_cnt_o + 1'b1;
      if (op == OP_CTRL && flush_cnt_o != CNT_MAX)
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: three instances (no bypass, WB bypass, 4-bit counters)
// share one instruction stream so their differing stall behaviour is checked side by side.
module tb_hazard_detect;

  typedef struct packed {
    logic       v;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] d;
    logic       we;
    logic       br;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, rs1_used, rs2_used, rd_wren, br_taken;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  op_a, op_b, op_c;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [3:0]  stall_c, flush_c;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  hazard_detect #(.WB_BYPASS(1'b0), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wren_i(rd_wren), .mem_br_taken_i(br_taken),
    .hazard_op_o(op_a), .data_stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
  );

  hazard_detect #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wren_i(rd_wren), .mem_br_taken_i(br_taken),
    .hazard_op_o(op_b), .data_stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
  );

  hazard_detect #(.WB_BYPASS(1'b0), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wren_i(rd_wren), .mem_br_taken_i(br_taken),
    .hazard_op_o(op_c), .data_stall_cnt_o(stall_c), .flush_cnt_o(flush_c)
  );

  function automatic vec_t mk(input int v, input int r1, input int u1, input int r2,
                              input int u2, input int d, input int we, input int br);
    vec_t t;
    t.v  = 1'(v);
    t.r1 = 5'(r1);
    t.u1 = 1'(u1);
    t.r2 = 5'(r2);
    t.u2 = 1'(u2);
    t.d  = 5'(d);
    t.we = 1'(we);
    t.br = 1'(br);
    return t;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v;
    rs1      = x.r1;
    rs1_used = x.u1;
    rs2      = x.r2;
    rs2_used = x.u2;
    rd       = x.d;
    rd_wren  = x.we;
    br_taken = x.br;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk(1, 5, 1, 5, 1, 5, 1, 1));
    @(negedge clk);
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b00_00_00) begin
      tests_failed++;
      $display("[TB] FAIL reset_op ops(a,b,c) got %b expected 000000", {op_a, op_b, op_c});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (stall_a !== 16'd0 || flush_a !== 16'd0 || flush_b !== 16'd0 || flush_c !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt got stall_a=%0d flush_a=%0d flush_b=%0d flush_c=%0d expected all 0",
               stall_a, flush_a, flush_b, flush_c);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(mk(1, 5, 1, 5, 1, 0, 0, 0));
    @(negedge clk);
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b00_00_00) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_op ops(a,b,c) got %b expected 000000", {op_a, op_b, op_c});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw_adjacent();
    vec_t       vt[6];
    logic [5:0] eo[6];
    do_reset();
    vt[0] = mk(1, 0, 0, 0, 0, 5, 1, 0); eo[0] = 6'b00_00_00;
    vt[1] = mk(1, 5, 1, 0, 1, 6, 1, 0); eo[1] = 6'b01_01_01;
    vt[2] = mk(1, 5, 1, 0, 1, 6, 1, 0); eo[2] = 6'b01_01_01;
    vt[3] = mk(1, 5, 1, 0, 1, 6, 1, 0); eo[3] = 6'b01_00_01;
    vt[4] = mk(1, 5, 1, 0, 1, 6, 1, 0); eo[4] = 6'b00_00_00;
    vt[5] = mk(0, 0, 0, 0, 0, 0, 0, 0); eo[5] = 6'b00_00_00;
    for (int c = 0; c < 6; c++) begin
      drive(vt[c]);
      @(negedge clk);
      tests_run++;
      if ({op_a, op_b, op_c} !== eo[c]) begin
        tests_failed++;
        $display("[TB] FAIL raw_adjacent cycle %0d ops(a,b,c) got %b expected %b",
                 c, {op_a, op_b, op_c}, eo[c]);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (stall_a !== 16'd3 || stall_b !== 16'd2 || stall_c !== 4'd3 || flush_a !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL raw_adjacent_cnt got a=%0d b=%0d c=%0d flush_a=%0d expected 3 2 3 0",
               stall_a, stall_b, stall_c, flush_a);
    end
  endtask

  task automatic test_one_between();
    vec_t       vt[5];
    logic [5:0] eo[5];
    do_reset();
    vt[0] = mk(1, 0, 0, 0, 0, 5, 1, 0); eo[0] = 6'b00_00_00;
    vt[1] = mk(1, 0, 0, 0, 0, 9, 1, 0); eo[1] = 6'b00_00_00;
    vt[2] = mk(1, 5, 1, 0, 0, 6, 1, 0); eo[2] = 6'b01_01_01;
    vt[3] = mk(1, 5, 1, 0, 0, 6, 1, 0); eo[3] = 6'b01_00_01;
    vt[4] = mk(1, 5, 1, 0, 0, 6, 1, 0); eo[4] = 6'b00_00_00;
    for (int c = 0; c < 5; c++) begin
      drive(vt[c]);
      @(negedge clk);
      tests_run++;
      if ({op_a, op_b, op_c} !== eo[c]) begin
        tests_failed++;
        $display("[TB] FAIL one_between cycle %0d ops(a,b,c) got %b expected %b",
                 c, {op_a, op_b, op_c}, eo[c]);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (stall_a !== 16'd2 || stall_b !== 16'd1 || stall_c !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL one_between_cnt got a=%0d b=%0d c=%0d expected 2 1 2",
               stall_a, stall_b, stall_c);
    end
  endtask

  task automatic test_x0_unused();
    vec_t vt[8];
    do_reset();
    vt[0] = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vt[1] = mk(1, 0, 1, 0, 1, 3, 0, 0);
    vt[2] = mk(1, 0, 1, 0, 1, 3, 0, 0);
    vt[3] = mk(1, 0, 0, 0, 0, 7, 1, 0);
    vt[4] = mk(1, 7, 0, 7, 0, 0, 0, 0);
    vt[5] = mk(0, 7, 1, 7, 1, 8, 1, 0);
    vt[6] = mk(1, 8, 1, 0, 0, 0, 0, 0);
    vt[7] = mk(1, 8, 1, 8, 1, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive(vt[c]);
      @(negedge clk);
      tests_run++;
      if ({op_a, op_b, op_c} !== 6'b00_00_00) begin
        tests_failed++;
        $display("[TB] FAIL x0_unused cycle %0d ops(a,b,c) got %b expected 000000",
                 c, {op_a, op_b, op_c});
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (stall_a !== 16'd0 || stall_b !== 16'd0 || stall_c !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL x0_unused_cnt got a=%0d b=%0d c=%0d expected 0 0 0",
               stall_a, stall_b, stall_c);
    end
  endtask

  task automatic test_control();
    vec_t       vt[6];
    logic [5:0] eo[6];
    do_reset();
    vt[0] = mk(1, 0, 0, 0, 0, 3, 1, 0); eo[0] = 6'b00_00_00;
    vt[1] = mk(1, 0, 0, 0, 0, 5, 1, 0); eo[1] = 6'b00_00_00;
    vt[2] = mk(1, 5, 1, 0, 0, 6, 1, 1); eo[2] = 6'b10_10_10;
    vt[3] = mk(1, 5, 1, 3, 1, 0, 0, 0); eo[3] = 6'b01_00_01;
    vt[4] = mk(0, 0, 0, 0, 0, 0, 0, 0); eo[4] = 6'b00_00_00;
    vt[5] = mk(0, 0, 0, 0, 0, 0, 0, 1); eo[5] = 6'b10_10_10;
    for (int c = 0; c < 6; c++) begin
      drive(vt[c]);
      @(negedge clk);
      tests_run++;
      if ({op_a, op_b, op_c} !== eo[c]) begin
        tests_failed++;
        $display("[TB] FAIL control cycle %0d ops(a,b,c) got %b expected %b",
                 c, {op_a, op_b, op_c}, eo[c]);
      end
      @(posedge clk);
      #1;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tests_run++;
    if (flush_a !== 16'd2 || flush_b !== 16'd2 || flush_c !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL control_flush_cnt got a=%0d b=%0d c=%0d expected 2 2 2",
               flush_a, flush_b, flush_c);
    end
    tests_run++;
    if (stall_a !== 16'd1 || stall_b !== 16'd0 || stall_c !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL control_stall_cnt got a=%0d b=%0d c=%0d expected 1 0 1",
               stall_a, stall_b, stall_c);
    end
  endtask

  task automatic test_saturation();
    logic [5:0] e;
    do_reset();
    // Each instruction reads and writes x5, so it always depends on its predecessor.
    for (int c = 0; c < 28; c++) begin
      drive(mk(1, 5, 1, 0, 0, 5, 1, 0));
      e = {((c % 4) != 0) ? 2'd1 : 2'd0, ((c % 3) != 0) ? 2'd1 : 2'd0,
           ((c % 4) != 0) ? 2'd1 : 2'd0};
      @(negedge clk);
      tests_run++;
      if ({op_a, op_b, op_c} !== e) begin
        tests_failed++;
        $display("[TB] FAIL saturation cycle %0d ops(a,b,c) got %b expected %b",
                 c, {op_a, op_b, op_c}, e);
      end
      @(posedge clk);
      #1;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tests_run++;
    if (stall_a !== 16'd21 || stall_b !== 16'd18 || stall_c !== 4'd15 || flush_c !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL saturation_cnt got a=%0d b=%0d c=%0d flush_c=%0d expected 21 18 15 0",
               stall_a, stall_b, stall_c, flush_c);
    end
  endtask

  task automatic test_mid_stall_reset();
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 5, 1, 0));
    @(posedge clk);
    #1;
    drive(mk(1, 5, 1, 0, 0, 6, 1, 0));
    @(negedge clk);
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b01_01_01) begin
      tests_failed++;
      $display("[TB] FAIL midreset_stall1 ops(a,b,c) got %b expected 010101", {op_a, op_b, op_c});
    end
    @(posedge clk);
    #2;
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b01_01_01 || stall_a !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_stall2 ops(a,b,c) got %b stall_a=%0d expected 010101 1",
               {op_a, op_b, op_c}, stall_a);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b00_00_00 || stall_a !== 16'd0 || stall_c !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async ops(a,b,c) got %b stall_a=%0d stall_c=%0d expected 000000 0 0",
               {op_a, op_b, op_c}, stall_a, stall_c);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({op_a, op_b, op_c} !== 6'b00_00_00) begin
      tests_failed++;
      $display("[TB] FAIL midreset_release ops(a,b,c) got %b expected 000000", {op_a, op_b, op_c});
    end
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    tests_run++;
    if (stall_a !== 16'd0 || stall_b !== 16'd0 || stall_c !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_cnt got a=%0d b=%0d c=%0d expected 0 0 0",
               stall_a, stall_b, stall_c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_raw_adjacent();
    test_one_between();
    test_x0_unused();
    test_control();
    test_saturation();
    test_mid_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
